// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one side of a pipeline stage.
// The producer drives valid/data and the consumer drives ready.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
) ();
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with an optional skid entry.
// It provides synchronous flush with bubble insertion, occupancy reporting
// and a saturating count of payloads killed by flush.
module pipe_stage_skid #(
  parameter int              DATA_W     = 64,
  parameter bit              SKID       = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int              DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  output logic [1:0]        occupancy,
  output logic [DROP_W-1:0] drop_cnt
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [1:0]        r_occ;
  logic [DROP_W-1:0] r_drop;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_consume;
  logic              w_main_free;
  logic [1:0]        w_drop_inc;
  logic              w_main_valid_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [1:0]        w_occ_nxt;
  logic [DROP_W-1:0] w_drop_nxt;

  // Add a small increment to the drop counter, clamping at all-ones.
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] cnt,
                                                input logic [1:0]        inc);
    logic [DROP_W:0] sum;
    sum = (DROP_W+1)'(cnt) + (DROP_W+1)'(inc);
    if (sum[DROP_W]) begin
      sat_add = {DROP_W{1'b1}};
    end else begin
      sat_add = sum[DROP_W-1:0];
    end
  endfunction

  assign w_main_free = ~r_main_valid | dn.ready;
  assign w_accept    = up.valid & w_in_ready;
  assign w_consume   = r_main_valid & dn.ready;
  // Entries held minus the one leaving downstream this cycle; never negative
  // because a consume implies the main entry is valid.
  assign w_drop_inc  = {1'b0, r_main_valid} + {1'b0, r_skid_valid} - {1'b0, w_consume};

  // Upstream ready: registered skid-empty flag with two entries, else pass-through of main-free.
  always_comb begin
    w_in_ready = 1'b0;
    if (SKID) begin
      w_in_ready = ~r_skid_valid & ~flush;
    end else begin
      w_in_ready = w_main_free & ~flush;
    end
  end

  // Next-state for both entries and the drop counter; flush empties everything.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    w_drop_nxt       = r_drop;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_main_data_nxt  = BUBBLE_VAL;
      w_skid_valid_nxt = 1'b0;
      w_skid_data_nxt  = BUBBLE_VAL;
      w_drop_nxt       = sat_add(r_drop, w_drop_inc);
    end else if (w_main_free) begin
      // Skid is older than anything arriving now, so it refills main first.
      if (r_skid_valid) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = r_skid_data;
        w_skid_valid_nxt = 1'b0;
        w_skid_data_nxt  = BUBBLE_VAL;
      end else if (w_accept) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = up.data;
      end else begin
        w_main_valid_nxt = 1'b0;
        w_main_data_nxt  = BUBBLE_VAL;
      end
    end else if (SKID && w_accept) begin
      // Main is stalled; in_ready guarantees the skid is empty here.
      w_skid_valid_nxt = 1'b1;
      w_skid_data_nxt  = up.data;
    end else begin
      w_skid_valid_nxt = r_skid_valid;
      w_skid_data_nxt  = r_skid_data;
    end
    w_occ_nxt = {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
  end

  // Stage state registers; reset discards held entries without counting drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= BUBBLE_VAL;
      r_skid_valid <= 1'b0;
      r_skid_data  <= BUBBLE_VAL;
      r_occ        <= 2'd0;
      r_drop       <= {DROP_W{1'b0}};
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_occ        <= w_occ_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  assign up.ready  = w_in_ready;
  assign dn.valid  = r_main_valid;
  assign dn.data   = r_main_data;
  assign occupancy = r_occ;
  assign drop_cnt  = r_drop;

endmodule
